// File: rtl/icu_pkg.sv
// Shared opcode definitions for the ICU family.
// Used by both the 1-bit ICU and the WIDTH-bit icu_wide.
package icu_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

endpackage

// File: rtl/icu_stack.sv
// Return-address LIFO for icu_wide.
// Shift-register organisation: entry 0 is always the top of stack.
module icu_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;

  assign dout  = mem[0];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Data needs no reset: the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++)
        mem[i] <= mem[i+1];
    end
  end

endmodule

// File: rtl/icu_wide.sv
// WIDTH-bit industrial control unit with on-chip PC and
// call/return stack; one instruction per X2 cycle.
module icu_wide
  import icu_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              X2,
  input  logic              RST,
  input  logic [3:0]        I,
  input  logic [ADDR_W-1:0] OPR,
  input  logic [WIDTH-1:0]  DATA_in,
  output logic [ADDR_W-1:0] PC,
  output logic [WIDTH-1:0]  DATA_out,
  output logic              WRITE,
  output logic              oeb,
  output logic [WIDTH-1:0]  RR,
  output logic              JMP,
  output logic              RTN,
  output logic              FLAG_O,
  output logic              FLAG_F,
  output logic              stack_err
);

  logic              ien;
  logic              oen;
  logic              skip;
  logic              exec;
  logic              store;
  logic              full;
  logic              empty;
  logic [WIDTH-1:0]  d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;

  assign exec   = !RST && !skip;
  assign store  = exec && (I == OP_STO || I == OP_STOC);
  assign WRITE  = store && oen;
  assign oeb    = !WRITE;
  assign DATA_out = WRITE ? ((I == OP_STOC) ? ~RR : RR) : '0;
  assign JMP    = exec && (I == OP_JMP);
  assign RTN    = exec && (I == OP_RTN);
  assign FLAG_O = exec && (I == OP_NOPO);
  assign FLAG_F = exec && (I == OP_NOPF);
  assign d      = DATA_in & {WIDTH{ien}};
  assign pc_inc = PC + ADDR_W'(1);

  icu_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (X2),
    .rst   (RST),
    .push  (JMP),
    .pop   (RTN),
    .din   (pc_inc),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge X2) begin
    if (RST) begin
      PC        <= '0;
      RR        <= '0;
      ien       <= 1'b0;
      oen       <= 1'b0;
      skip      <= 1'b0;
      stack_err <= 1'b0;
    end else if (skip) begin
      PC   <= pc_inc;
      skip <= 1'b0;
    end else begin
      PC   <= pc_inc;
      skip <= 1'b0;
      unique case (I)
        OP_LD:   RR  <= d;
        OP_LDC:  RR  <= ~d;
        OP_AND:  RR  <= RR & d;
        OP_ANDC: RR  <= RR & ~d;
        OP_OR:   RR  <= RR | d;
        OP_ORC:  RR  <= RR | ~d;
        OP_XNOR: RR  <= ~(RR ^ d);
        OP_IEN:  ien <= DATA_in[0];
        OP_OEN:  oen <= DATA_in[0];
        OP_JMP: begin
          PC <= OPR;
          if (full) stack_err <= 1'b1;
        end
        // Return skips the instruction after the call site.
        OP_RTN: begin
          skip <= 1'b1;
          if (empty) stack_err <= 1'b1;
          else PC <= top;
        end
        OP_SKZ:  skip <= ~|RR;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icu_wide.sv
// Directed plus randomized bench for icu_wide (WIDTH=4, depth 2)
// against a queue-based reference model.
module tb_icu_wide;
  import icu_pkg::*;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int SD = 2;

  logic          X2 = 1'b0;
  logic          RST = 1'b1;
  logic [3:0]    I = 4'h0;
  logic [AW-1:0] OPR = '0;
  logic [W-1:0]  DATA_in = '0;
  logic [AW-1:0] PC;
  logic [W-1:0]  DATA_out;
  logic          WRITE, oeb, JMP, RTN, FLAG_O, FLAG_F, stack_err;
  logic [W-1:0]  RR;

  icu_wide #(.WIDTH(W), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .X2(X2), .RST(RST), .I(I), .OPR(OPR), .DATA_in(DATA_in),
    .PC(PC), .DATA_out(DATA_out), .WRITE(WRITE), .oeb(oeb),
    .RR(RR), .JMP(JMP), .RTN(RTN), .FLAG_O(FLAG_O),
    .FLAG_F(FLAG_F), .stack_err(stack_err)
  );

  always #5 X2 = ~X2;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_pc = '0;
  logic [W-1:0]  m_rr = '0;
  logic          m_ien = 0, m_oen = 0, m_skip = 0, m_err = 0;
  logic [AW-1:0] stk [$];

  logic o_write, o_oeb, o_jmp, o_rtn, o_fo, o_ff;
  logic [W-1:0] o_dout;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [AW-1:0] opr,
                      input logic [W-1:0] din, input logic rst);
    logic ex, e_wr;
    logic [W-1:0] e_do, d;
    logic [AW-1:0] nxt;
    @(negedge X2);
    I = op; OPR = opr; DATA_in = din; RST = rst;
    #1;
    ex   = !rst && !m_skip;
    e_wr = ex && (op == OP_STO || op == OP_STOC) && m_oen;
    e_do = e_wr ? ((op == OP_STOC) ? ~m_rr : m_rr) : '0;
    o_write = WRITE; o_oeb = oeb; o_dout = DATA_out;
    o_jmp = JMP; o_rtn = RTN; o_fo = FLAG_O; o_ff = FLAG_F;
    chk("write", {31'b0, WRITE}, {31'b0, e_wr});
    chk("oeb", {31'b0, oeb}, {31'b0, !e_wr});
    chk("data_out", {28'b0, DATA_out}, {28'b0, e_do});
    chk("jmp", {31'b0, JMP}, {31'b0, ex && op == OP_JMP});
    chk("rtn", {31'b0, RTN}, {31'b0, ex && op == OP_RTN});
    chk("flag_o", {31'b0, FLAG_O}, {31'b0, ex && op == OP_NOPO});
    chk("flag_f", {31'b0, FLAG_F}, {31'b0, ex && op == OP_NOPF});
    @(posedge X2);
    if (rst) begin
      m_pc = '0; m_rr = '0; m_ien = 0; m_oen = 0;
      m_skip = 0; m_err = 0; stk.delete();
    end else if (m_skip) begin
      m_pc = m_pc + 1'b1;
      m_skip = 0;
    end else begin
      d = m_ien ? din : '0;
      nxt = m_pc + 1'b1;
      m_skip = 0;
      case (op)
        OP_LD:   m_rr = d;
        OP_LDC:  m_rr = ~d;
        OP_AND:  m_rr = m_rr & d;
        OP_ANDC: m_rr = m_rr & ~d;
        OP_OR:   m_rr = m_rr | d;
        OP_ORC:  m_rr = m_rr | ~d;
        OP_XNOR: m_rr = ~(m_rr ^ d);
        OP_IEN:  m_ien = din[0];
        OP_OEN:  m_oen = din[0];
        OP_JMP: begin
          if (stk.size() < SD) stk.push_back(nxt);
          else m_err = 1;
          nxt = opr;
        end
        OP_RTN: begin
          if (stk.size() > 0) nxt = stk.pop_back();
          else m_err = 1;
          m_skip = 1;
        end
        OP_SKZ:  m_skip = (m_rr == 0);
        default: ;
      endcase
      m_pc = nxt;
    end
    #1;
    chk("pc", {24'b0, PC}, {24'b0, m_pc});
    chk("rr", {28'b0, RR}, {28'b0, m_rr});
    chk("stack_err", {31'b0, stack_err}, {31'b0, m_err});
  endtask

  logic [AW-1:0] pc0;

  initial begin
    // reset and defaults
    step(OP_NOPO, 0, 0, 1);
    step(OP_NOPO, 0, 0, 1);
    chk("rst_pc", {24'b0, PC}, 32'h0);
    chk("rst_rr", {28'b0, RR}, 32'h0);
    chk("rst_err", {31'b0, stack_err}, 32'h0);
    step(OP_LD, 0, 4'hA, 0);
    chk("rst_oeb", {31'b0, o_oeb}, 32'h1);
    chk("ld_ien0", {28'b0, RR}, 32'h0);

    // logic ops
    step(OP_IEN, 0, 4'h1, 0);
    step(OP_LD, 0, 4'hC, 0);   chk("ld_c", {28'b0, RR}, 32'hC);
    step(OP_AND, 0, 4'hA, 0);  chk("and_a", {28'b0, RR}, 32'h8);
    step(OP_ORC, 0, 4'h1, 0);  chk("orc_1", {28'b0, RR}, 32'hE);
    step(OP_XNOR, 0, 4'h5, 0); chk("xnor_5", {28'b0, RR}, 32'h4);
    step(OP_OEN, 0, 4'h1, 0);
    step(OP_STOC, 0, 4'h0, 0);
    chk("stoc_wr", {31'b0, o_write}, 32'h1);
    chk("stoc_oeb", {31'b0, o_oeb}, 32'h0);
    chk("stoc_do", {28'b0, o_dout}, 32'hB);

    // skip
    step(OP_LD, 0, 4'h0, 0);
    pc0 = PC;
    step(OP_SKZ, 0, 0, 0);
    step(OP_LD, 0, 4'hF, 0);
    chk("skz_rr", {28'b0, RR}, 32'h0);
    chk("skz_pc", {24'b0, PC}, {24'b0, pc0 + 8'd2});
    step(OP_LD, 0, 4'h1, 0);
    step(OP_SKZ, 0, 0, 0);
    step(OP_LD, 0, 4'hF, 0);
    chk("skz_nz", {28'b0, RR}, 32'hF);

    // call/return
    step(OP_NOPO, 0, 0, 1);
    repeat (5) step(OP_NOPO, 0, 0, 0);
    chk("pc5", {24'b0, PC}, 32'h5);
    step(OP_JMP, 8'h40, 0, 0);
    chk("jmp_strobe", {31'b0, o_jmp}, 32'h1);
    chk("jmp_pc", {24'b0, PC}, 32'h40);
    step(OP_RTN, 0, 0, 0);
    chk("rtn_pc", {24'b0, PC}, 32'h6);
    step(OP_NOPF, 0, 0, 0);
    chk("skip_ff", {31'b0, o_ff}, 32'h0);
    chk("pc7", {24'b0, PC}, 32'h7);
    step(OP_NOPO, 0, 0, 0);
    chk("exec7", {31'b0, o_fo}, 32'h1);

    // stack errors
    step(OP_NOPO, 0, 0, 1);
    step(OP_JMP, 8'h10, 0, 0);
    step(OP_JMP, 8'h20, 0, 0);
    chk("err_clear", {31'b0, stack_err}, 32'h0);
    step(OP_JMP, 8'h30, 0, 0);
    chk("ovf_pc", {24'b0, PC}, 32'h30);
    chk("ovf_err", {31'b0, stack_err}, 32'h1);
    step(OP_RTN, 0, 0, 0);
    chk("rtn1", {24'b0, PC}, 32'h11);
    step(OP_NOPO, 0, 0, 0);
    step(OP_RTN, 0, 0, 0);
    chk("rtn2", {24'b0, PC}, 32'h01);
    step(OP_NOPO, 0, 0, 0);
    step(OP_RTN, 0, 0, 0);
    chk("unf_strobe", {31'b0, o_rtn}, 32'h1);
    chk("unf_pc", {24'b0, PC}, 32'h03);
    step(OP_NOPO, 0, 0, 0);
    chk("unf_skip", {31'b0, o_fo}, 32'h0);
    chk("unf_err", {31'b0, stack_err}, 32'h1);

    // wrap and mid-run reset
    step(OP_NOPO, 0, 0, 1);
    step(OP_JMP, 8'hFF, 0, 0);
    step(OP_NOPO, 0, 0, 0);
    chk("wrap_pc", {24'b0, PC}, 32'h0);
    step(OP_IEN, 0, 4'h1, 0);
    step(OP_LD, 0, 4'h9, 0);
    step(OP_OEN, 0, 4'h1, 0);
    step(OP_STO, 0, 0, 1);
    chk("rst_sto_wr", {31'b0, o_write}, 32'h0);
    chk("rst_sto_pc", {24'b0, PC}, 32'h0);
    chk("rst_sto_rr", {28'b0, RR}, 32'h0);

    // randomized run against the model
    for (int n = 0; n < 600; n++)
      step(4'($urandom_range(15)), 8'($urandom),
           4'($urandom), ($urandom_range(40) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
